// File: rtl/bus_slave_regs_pkg.sv
// bus_slave_regs_pkg
//   Shared bus definitions for the generic register slave and for future
//   peripherals built on the same wait-state controller.
//   - `WORD_DATA_W / `WORD_ADDR_W : bus data / word-address widths
//   - `READ / `WRITE              : s_rw encodings
//   - `ENABLE_ / `DISABLE_        : levels of the active-low strobes
//   The macros are mirrored as package localparams so RTL can use typed
//   constants after "import bus_slave_regs_pkg::*".
//   Also holds the 2-bit slave FSM state encoding.

`ifndef WORD_DATA_W
`define WORD_DATA_W 32
`endif
`ifndef WORD_ADDR_W
`define WORD_ADDR_W 30
`endif
`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif
`ifndef ENABLE_
`define ENABLE_ 1'b0
`endif
`ifndef DISABLE_
`define DISABLE_ 1'b1
`endif

package bus_slave_regs_pkg;

    localparam int   WORD_DATA_W = `WORD_DATA_W;
    localparam int   WORD_ADDR_W = `WORD_ADDR_W;
    localparam logic READ        = `READ;
    localparam logic WRITE       = `WRITE;
    localparam logic ENABLE_     = `ENABLE_;
    localparam logic DISABLE_    = `DISABLE_;

    typedef enum logic [1:0] {
        BUS_SLV_IDLE = 2'd0,
        BUS_SLV_WAIT = 2'd1,
        BUS_SLV_RESP = 2'd2
    } bus_slv_state_e;

    // A request is present when both chip select and address strobe are low.
    function automatic logic bus_req(input logic cs_, input logic as_);
        return (cs_ == ENABLE_) && (as_ == ENABLE_);
    endfunction

endpackage

// File: rtl/bus_slave_regs_if.sv
// bus_slave_regs_if
//   Slave-port bundle between the address decoder / master and one slave.
//   master modport drives s_cs_, s_as_, s_rw, s_addr, s_wr_data and
//   receives s_rd_data, s_rdy_; slave modport is the mirror image.

interface bus_slave_regs_if;
    import bus_slave_regs_pkg::*;

    logic                   s_cs_;
    logic                   s_as_;
    logic                   s_rw;
    logic [WORD_ADDR_W-1:0] s_addr;
    logic [WORD_DATA_W-1:0] s_wr_data;
    logic [WORD_DATA_W-1:0] s_rd_data;
    logic                   s_rdy_;

    modport master (
        output s_cs_, s_as_, s_rw, s_addr, s_wr_data,
        input  s_rd_data, s_rdy_
    );

    modport slave (
        input  s_cs_, s_as_, s_rw, s_addr, s_wr_data,
        output s_rd_data, s_rdy_
    );

endinterface

// File: rtl/bus_slave_wait_ctrl.sv
// bus_slave_wait_ctrl
//   Request/wait-state/response sequencer for a simple bus slave.
//   Ports:
//     clk, reset     : clock, asynchronous active-high reset
//     i_cs_, i_as_   : chip select / address strobe (active low)
//     o_capture_en   : high in the cycle whose closing edge captures a request
//     o_resp_en      : high in the cycle whose closing edge enters RESP
//   Both strobes describe what the coming clock edge does, so the owner can
//   commit writes and register its response on exactly that edge.
//   Parameter WAIT_CYCLES (0..15): wait states between capture and response.

module bus_slave_wait_ctrl
    import bus_slave_regs_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_cs_,
    input  logic i_as_,
    output logic o_capture_en,
    output logic o_resp_en
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    bus_slv_state_e r_state;
    logic [3:0]     r_cnt;
    logic           w_req;
    logic           w_wait_done;

    assign w_req        = bus_req(i_cs_, i_as_);
    assign o_capture_en = (r_state == BUS_SLV_IDLE) && w_req;
    // s_as_ is ignored while waiting; only a dropped chip select aborts.
    assign w_wait_done  = (r_state == BUS_SLV_WAIT) && (i_cs_ == ENABLE_) && (r_cnt == 4'd0);
    assign o_resp_en    = (o_capture_en && (WAIT_CYCLES == 0)) || w_wait_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BUS_SLV_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                BUS_SLV_IDLE: begin
                    if (w_req) begin
                        if (WAIT_CYCLES == 0) begin
                            r_state <= BUS_SLV_RESP;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= BUS_SLV_WAIT;
                        end
                    end
                end
                BUS_SLV_WAIT: begin
                    if (i_cs_ == DISABLE_) begin
                        r_state <= BUS_SLV_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= BUS_SLV_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                BUS_SLV_RESP: r_state <= BUS_SLV_IDLE;
                default:      r_state <= BUS_SLV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bus_slave_regs.sv
// bus_slave_regs
//   Generic bus slave: NUM_REGS x 32-bit read/write registers behind a
//   programmable wait-state generator (bus_slave_wait_ctrl).
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     bus        : bus_slave_regs_if.slave (s_cs_, s_as_, s_rw, s_addr,
//                  s_wr_data in; s_rd_data, s_rdy_ out, both registered)
//   Parameters: NUM_REGS (power of two, 2..256), IDX_W = log2(NUM_REGS),
//               WAIT_CYCLES (0..15).
//   Optional macro BUS_SLAVE_REGS_STATUS_EN: register NUM_REGS-1 becomes a
//   read-only count of completed transactions; writes to it are accepted
//   and discarded.

module bus_slave_regs
    import bus_slave_regs_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int IDX_W       = 3,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    bus_slave_regs_if.slave  bus
);

    logic                   w_capture_en;
    logic                   w_resp_en;
    logic                   w_wr_commit;

    logic [IDX_W-1:0]       r_idx;
    logic                   r_rw;
    logic [WORD_DATA_W-1:0] r_wr_data;

    logic [IDX_W-1:0]       w_idx;
    logic                   w_rw;
    logic [WORD_DATA_W-1:0] w_wr_data;

    logic [WORD_DATA_W-1:0] r_regs [NUM_REGS];
    logic [WORD_DATA_W-1:0] r_rd_data;
    logic                   r_rdy_;

    logic                   w_unused_addr;

    bus_slave_wait_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctrl (
        .clk          (clk),
        .reset        (reset),
        .i_cs_        (bus.s_cs_),
        .i_as_        (bus.s_as_),
        .o_capture_en (w_capture_en),
        .o_resp_en    (w_resp_en)
    );

    // Upper address bits belong to the decoder, not to this slave.
    assign w_unused_addr = ^bus.s_addr[WORD_ADDR_W-1:IDX_W];

    // With zero wait states the capture and response edges coincide, so the
    // live bus values must be used instead of the (not yet loaded) capture.
    assign w_idx     = w_capture_en ? bus.s_addr[IDX_W-1:0] : r_idx;
    assign w_rw      = w_capture_en ? bus.s_rw              : r_rw;
    assign w_wr_data = w_capture_en ? bus.s_wr_data         : r_wr_data;

`ifdef BUS_SLAVE_REGS_STATUS_EN
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS - 1);
    assign w_wr_commit = w_resp_en && (w_rw == WRITE) && (w_idx != STATUS_IDX);
`else
    assign w_wr_commit = w_resp_en && (w_rw == WRITE);
`endif

    // Request capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx     <= '0;
            r_rw      <= 1'b0;
            r_wr_data <= '0;
        end else if (w_capture_en) begin
            r_idx     <= bus.s_addr[IDX_W-1:0];
            r_rw      <= bus.s_rw;
            r_wr_data <= bus.s_wr_data;
        end
    end

    // Register bank; writes land on the edge that enters RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr_commit) begin
                r_regs[w_idx] <= w_wr_data;
            end
`ifdef BUS_SLAVE_REGS_STATUS_EN
            // Counter bumps on the same edge the read data is sampled, so a
            // read of it reports prior transactions only.
            if (w_resp_en) begin
                r_regs[NUM_REGS-1] <= r_regs[NUM_REGS-1] + WORD_DATA_W'(1);
            end
`endif
        end
    end

    // Registered response: one cycle of rdy_ low, data zero otherwise so the
    // response mux can OR slaves together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy_    <= DISABLE_;
            r_rd_data <= '0;
        end else if (w_resp_en) begin
            r_rdy_    <= ENABLE_;
            r_rd_data <= (w_rw == READ) ? r_regs[w_idx] : '0;
        end else begin
            r_rdy_    <= DISABLE_;
            r_rd_data <= '0;
        end
    end

    assign bus.s_rdy_    = r_rdy_;
    assign bus.s_rd_data = r_rd_data;

endmodule

// File: tb/tb_bus_slave_regs.sv
module tb_bus_slave_regs;
    import bus_slave_regs_pkg::*;

    localparam int NR = 8;
    localparam int NI = 3;
    localparam int WC [NI] = '{0, 1, 2};
`ifdef BUS_SLAVE_REGS_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                   drv_cs   [NI];
    logic                   drv_as   [NI];
    logic                   drv_rw   [NI];
    logic [WORD_ADDR_W-1:0] drv_addr [NI];
    logic [31:0]            drv_wd   [NI];
    logic                   dut_rdy  [NI];
    logic [31:0]            dut_rd   [NI];

    bus_slave_regs_if bif0 ();
    bus_slave_regs_if bif1 ();
    bus_slave_regs_if bif2 ();

    assign bif0.s_cs_ = drv_cs[0]; assign bif0.s_as_ = drv_as[0]; assign bif0.s_rw = drv_rw[0];
    assign bif0.s_addr = drv_addr[0]; assign bif0.s_wr_data = drv_wd[0];
    assign bif1.s_cs_ = drv_cs[1]; assign bif1.s_as_ = drv_as[1]; assign bif1.s_rw = drv_rw[1];
    assign bif1.s_addr = drv_addr[1]; assign bif1.s_wr_data = drv_wd[1];
    assign bif2.s_cs_ = drv_cs[2]; assign bif2.s_as_ = drv_as[2]; assign bif2.s_rw = drv_rw[2];
    assign bif2.s_addr = drv_addr[2]; assign bif2.s_wr_data = drv_wd[2];
    assign dut_rdy[0] = bif0.s_rdy_; assign dut_rd[0] = bif0.s_rd_data;
    assign dut_rdy[1] = bif1.s_rdy_; assign dut_rd[1] = bif1.s_rd_data;
    assign dut_rdy[2] = bif2.s_rdy_; assign dut_rd[2] = bif2.s_rd_data;

    bus_slave_regs #(.NUM_REGS(NR), .IDX_W(3), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bif0));
    bus_slave_regs #(.NUM_REGS(NR), .IDX_W(3), .WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bif1));
    bus_slave_regs #(.NUM_REGS(NR), .IDX_W(3), .WAIT_CYCLES(2)) dut2 (.clk(clk), .reset(reset), .bus(bif2));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transaction view: an accepted request is due at an absolute cycle
    // number; it is dropped if chip select goes away before then.
    logic [31:0] m_regs [NI][NR];
    logic [31:0] m_cnt  [NI];
    bit          m_pend [NI];
    int          m_due  [NI];
    logic        m_rw   [NI];
    int          m_idx  [NI];
    logic [31:0] m_wd   [NI];
    logic        exp_rdy[NI];
    logic [31:0] exp_rd [NI];
    int          cyc = 0;

    always @(posedge clk) begin
        cyc++;
        for (int j = 0; j < NI; j++) begin
            bit respond;
            respond = 1'b0;
            if (reset) begin
                for (int r = 0; r < NR; r++) m_regs[j][r] = '0;
                m_cnt[j] = '0; m_pend[j] = 1'b0;
                exp_rdy[j] = 1'b1; exp_rd[j] = '0;
            end else if (exp_rdy[j] == 1'b0) begin
                exp_rdy[j] = 1'b1; exp_rd[j] = '0;
            end else begin
                if (m_pend[j]) begin
                    if (drv_cs[j]) m_pend[j] = 1'b0;
                    else if (cyc == m_due[j]) respond = 1'b1;
                end else if (!drv_cs[j] && !drv_as[j]) begin
                    m_rw[j] = drv_rw[j];
                    m_idx[j] = int'(drv_addr[j] % NR);
                    m_wd[j] = drv_wd[j];
                    if (WC[j] == 0) respond = 1'b1;
                    else begin m_pend[j] = 1'b1; m_due[j] = cyc + WC[j]; end
                end
                if (respond) begin
                    m_pend[j] = 1'b0;
                    if (m_rw[j] == READ) begin
                        exp_rd[j] = (STAT && m_idx[j] == NR-1) ? m_cnt[j] : m_regs[j][m_idx[j]];
                    end else begin
                        exp_rd[j] = '0;
                        if (!(STAT && m_idx[j] == NR-1)) m_regs[j][m_idx[j]] = m_wd[j];
                    end
                    m_cnt[j] = m_cnt[j] + 1;
                    exp_rdy[j] = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of all three slaves against the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int j = 0; j < NI; j++) begin
                chk($sformatf("cyc dut%0d rdy_", j), {31'd0, dut_rdy[j]}, {31'd0, exp_rdy[j]});
                chk($sformatf("cyc dut%0d rd_data", j), dut_rd[j], exp_rd[j]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [WORD_ADDR_W-1:0] addr_of(input int idx);
        // Upper bits set to show the slave ignores them.
        return WORD_ADDR_W'(32'h0ABC_0000) | WORD_ADDR_W'(idx);
    endfunction

    task automatic drive(input int j, input logic rw, input int idx, input logic [31:0] wd);
        @(negedge clk);
        drv_cs[j] = 1'b0; drv_as[j] = 1'b0; drv_rw[j] = rw;
        drv_addr[j] = addr_of(idx); drv_wd[j] = wd;
    endtask

    task automatic release_bus(input int j);
        @(negedge clk);
        drv_cs[j] = 1'b1; drv_as[j] = 1'b1;
    endtask

    // lat = number of edges from the capture edge (counted as 1) to rdy_ low.
    task automatic wait_rdy(input int j, output logic [31:0] d, output int lat);
        lat = 0; d = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (dut_rdy[j] == ENABLE_) begin
                lat = n; d = dut_rd[j];
                return;
            end
        end
        chk($sformatf("dut%0d rdy_ timeout", j), 32'd0, 32'd1);
    endtask

    task automatic txn(input int j, input logic rw, input int idx, input logic [31:0] wd,
                       output logic [31:0] d, output int lat);
        drive(j, rw, idx, wd);
        wait_rdy(j, d, lat);
        release_bus(j);
    endtask

    task automatic watch_quiet(input int j, input int n, input string name);
        int lows;
        lows = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (dut_rdy[j] == ENABLE_) lows++;
        end
        chk(name, lows, 0);
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] d;
    int          lat;

    initial begin
        for (int j = 0; j < NI; j++) begin
            drv_cs[j] = 1'b1; drv_as[j] = 1'b1; drv_rw[j] = READ;
            drv_addr[j] = '0; drv_wd[j] = '0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("reset dut%0d rdy_", j), {31'd0, dut_rdy[j]}, 32'd1);
            chk($sformatf("reset dut%0d rd_data", j), dut_rd[j], 32'd0);
        end
        @(negedge clk); reset = 1'b0;

        // Write then read, two wait states: response 3 edges after capture.
        txn(2, WRITE, 3, 32'hDEAD_BEEF, d, lat);
        chk("w2 write lat", lat, 3);
        chk("w2 write rd_data", d, 32'd0);
        txn(2, READ, 3, 32'h0, d, lat);
        chk("w2 read lat", lat, 3);
        chk("w2 read data", d, 32'hDEAD_BEEF);

        // Zero wait states: fill, then back-to-back reads with strobes held.
        for (int i = 0; i < NR; i++) begin
            txn(0, WRITE, i, 32'h1000_0000 + 32'(i) * 32'h11, d, lat);
            chk($sformatf("w0 write lat %0d", i), lat, 1);
        end
        drive(0, READ, 0, 32'h0);
        for (int i = 0; i < NR; i++) begin
            wait_rdy(0, d, lat);
            chk($sformatf("b2b lat %0d", i), lat, (i == 0) ? 1 : 2);
            chk($sformatf("b2b data %0d", i), d, 32'h1000_0000 + 32'(i) * 32'h11);
            @(negedge clk);
            if (i < NR-1) drv_addr[0] = addr_of(i + 1);
            else begin drv_cs[0] = 1'b1; drv_as[0] = 1'b1; end
        end

        // Abort: chip select dropped during WAIT of a write.
        txn(2, WRITE, 5, 32'hCAFE_0005, d, lat);
        drive(2, WRITE, 5, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk); drv_cs[2] = 1'b1; drv_as[2] = 1'b1;
        watch_quiet(2, 6, "abort no rdy_");
        txn(2, READ, 5, 32'h0, d, lat);
        chk("abort old value kept", d, 32'hCAFE_0005);

        // Reset in the middle of WAIT of a write.
        drive(2, WRITE, 1, 32'h0BAD_F00D);
        @(posedge clk);
        @(negedge clk); reset = 1'b1; drv_cs[2] = 1'b1; drv_as[2] = 1'b1;
        #1;
        chk("rst mid-wait rdy_", {31'd0, dut_rdy[2]}, 32'd1);
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        watch_quiet(2, 6, "rst mid-wait no rdy_");
        txn(2, READ, 1, 32'h0, d, lat);
        chk("rst dropped write", d, 32'd0);
        txn(2, READ, 3, 32'h0, d, lat);
        chk("rst cleared reg3", d, 32'd0);

        // One wait state; reset asserted mid-cycle during a read response.
        txn(1, WRITE, 2, 32'h0000_0077, d, lat);
        chk("w1 write lat", lat, 2);
        drive(1, READ, 2, 32'h0);
        wait_rdy(1, d, lat);
        chk("w1 read lat", lat, 2);
        chk("w1 read data", d, 32'h0000_0077);
        #2 reset = 1'b1;
        #1;
        chk("async rst rdy_", {31'd0, dut_rdy[1]}, 32'd1);
        chk("async rst rd_data", dut_rd[1], 32'd0);
        @(negedge clk); drv_cs[1] = 1'b1; drv_as[1] = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            txn(1, READ, i, 32'h0, d, lat);
            chk($sformatf("post-rst read %0d", i), d, 32'd0);
        end

        // Top register: status counter when enabled, plain R/W otherwise.
        for (int i = 0; i < 5; i++) txn(0, WRITE, i, 32'hA5A5_0000 + 32'(i), d, lat);
        txn(0, READ, NR-1, 32'h0, d, lat);
        chk("top reg first read", d, STAT ? 32'd5 : 32'd0);
        txn(0, WRITE, NR-1, 32'hFFFF_FFFF, d, lat);
        chk("top reg write lat", lat, 1);
        txn(0, READ, NR-1, 32'h0, d, lat);
        chk("top reg second read", d, STAT ? 32'd7 : 32'hFFFF_FFFF);
        txn(0, READ, 4, 32'h0, d, lat);
        chk("reg4 value", d, 32'hA5A5_0004);

        repeat (3) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
